// File: rtl/uart_pkg.sv
// Shared UART framing definitions: escape symbol and TX escape-encoder state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ESC_DEFAULT = 8'hB1;

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_prefix = 2'd1,
    st_byte   = 2'd2
  } tx_esc_state_t;

endpackage

// File: rtl/tx_escape.sv
// Transmit-side escape encoder: forwards TAP bytes to UART-TX, inserting ESC before
// commands and before data bytes equal to ESC.
module tx_escape
  import uart_pkg::*;
#(
  parameter logic [BYTE_W-1:0] ESC = ESC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BYTE_W-1:0] data_send_i,
  input  logic              command_i,
  input  logic              write_i,
  output logic              tx_ready_o,
  output logic              err_o,
  input  logic              tx_ready_i,
  output logic              write_o,
  output logic [BYTE_W-1:0] data_send_o
);

  tx_esc_state_t     state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              err_q, err_d;
  logic              alive_q;

  // State and latched byte; alive_q keeps TX_READY_O low until the first edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= st_idle;
      byte_q  <= '0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state: an illegal command (value == ESC) is dropped and flagged instead of sent.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    err_d   = 1'b0;
    unique case (state_q)
      st_idle: begin
        if (write_i && alive_q) begin
          byte_d = data_send_i;
          if (command_i && (data_send_i == ESC)) begin
            err_d = 1'b1;
          end else if (command_i || (data_send_i == ESC)) begin
            state_d = st_prefix;
          end else begin
            state_d = st_byte;
          end
        end
      end
      st_prefix: if (tx_ready_i) state_d = st_byte;
      st_byte:   if (tx_ready_i) state_d = st_idle;
      default:   state_d = st_idle;
    endcase
  end

  // Outputs: UART-side strobe follows tx_ready_i in the same cycle.
  always_comb begin
    tx_ready_o  = alive_q && (state_q == st_idle);
    err_o       = err_q;
    write_o     = 1'b0;
    data_send_o = '0;
    unique case (state_q)
      st_prefix: begin
        write_o     = tx_ready_i;
        data_send_o = ESC;
      end
      st_byte: begin
        write_o     = tx_ready_i;
        data_send_o = byte_q;
      end
      default: begin
        write_o     = 1'b0;
        data_send_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_escape.sv
// Bench for tx_escape: directed scenarios plus a random stream decoded back by an
// escape-protocol reader and compared against the accepted TAP sequence.
module tb_tx_escape;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] data_send_i;
  logic       command_i;
  logic       write_i;
  logic       tx_ready_o;
  logic       err_o;
  logic       tx_ready_i;
  logic       write_o;
  logic [7:0] data_send_o;

  int errors = 0;
  int checks = 0;

  logic       s_wr, s_rdy, s_err;
  logic [7:0] s_data;

  tx_escape dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .data_send_i (data_send_i),
    .command_i   (command_i),
    .write_i     (write_i),
    .tx_ready_o  (tx_ready_o),
    .err_o       (err_o),
    .tx_ready_i  (tx_ready_i),
    .write_o     (write_o),
    .data_send_o (data_send_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge; sample outputs on the following falling edge.
  task automatic step(input logic wr, input logic cmd, input logic [7:0] d, input logic trdy);
    @(posedge clk);
    #1;
    write_i     = wr;
    command_i   = cmd;
    data_send_i = d;
    tx_ready_i  = trdy;
    @(negedge clk);
    s_wr   = write_o;
    s_rdy  = tx_ready_o;
    s_err  = err_o;
    s_data = data_send_o;
  endtask

  logic [8:0] in_q[$];
  logic [8:0] dec;
  logic       esc_pend;
  logic       cur_cmd;
  logic [7:0] cur_d;
  logic       wr;
  logic       trdy;
  int         n_acc;
  int         cyc;

  initial begin
    rst_ni = 1'b0; write_i = 1'b0; command_i = 1'b0; data_send_i = 8'h00; tx_ready_i = 1'b1;
    #1;
    chk("rst_tx_ready", 9'(tx_ready_o), 9'd0);
    chk("rst_write", 9'(write_o), 9'd0);
    chk("rst_data", 9'(data_send_o), 9'h00);
    chk("rst_err", 9'(err_o), 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_ready", 9'(s_rdy), 9'd1);

    // Plain data byte
    step(1'b1, 1'b0, 8'h41, 1'b1);
    chk("t1_accept_ready", 9'(s_rdy), 9'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1_write", 9'(s_wr), 9'd1);
    chk("t1_data", 9'(s_data), 9'h41);
    chk("t1_busy", 9'(s_rdy), 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1_idle_wr", 9'(s_wr), 9'd0);
    chk("t1_idle_rdy", 9'(s_rdy), 9'd1);

    // Data equal to ESC is doubled
    step(1'b1, 1'b0, 8'hB1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_w1", {s_wr, s_data}, {1'b1, 8'hB1});
    chk("t2_rdy1", 9'(s_rdy), 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_w2", {s_wr, s_data}, {1'b1, 8'hB1});
    chk("t2_rdy2", 9'(s_rdy), 9'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_done", {s_wr, s_rdy, 7'd0}, {1'b0, 1'b1, 7'd0});

    // Command with backpressure between prefix and payload
    step(1'b1, 1'b1, 8'h05, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_prefix", {s_wr, s_data}, {1'b1, 8'hB1});
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h77, 1'b0);
      chk("t3_hold", {s_wr, s_data}, {1'b0, 8'h05});
      chk("t3_hold_rdy", 9'(s_rdy), 9'd0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_payload", {s_wr, s_data}, {1'b1, 8'h05});
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_idle", {s_wr, s_rdy, 7'd0}, {1'b0, 1'b1, 7'd0});

    // Illegal command: error pulse, nothing sent, next data byte goes through
    step(1'b1, 1'b1, 8'hB1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t4_err", 9'(s_err), 9'd1);
    chk("t4_nowr", 9'(s_wr), 9'd0);
    chk("t4_rdy", 9'(s_rdy), 9'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_err_gone", 9'(s_err), 9'd0);
    chk("t4_data", {s_wr, s_data}, {1'b1, 8'h00});

    // Async reset after the prefix of a command is written
    step(1'b1, 1'b1, 8'h07, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_prefix", {s_wr, s_data}, {1'b1, 8'hB1});
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_wr", 9'(write_o), 9'd0);
    chk("t5_rst_data", 9'(data_send_o), 9'h00);
    chk("t5_rst_rdy", 9'(tx_ready_o), 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_rel_rdy", 9'(s_rdy), 9'd1);
    chk("t5_rel_wr", 9'(s_wr), 9'd0);

    // Random stream, decoded back with the escape rules
    esc_pend = 1'b0;
    n_acc    = 0;
    cyc      = 0;
    cur_cmd  = ($urandom_range(3) == 0);
    cur_d    = ($urandom_range(3) == 0) ? ESC_DEFAULT : 8'($urandom);
    if (cur_cmd && cur_d == ESC_DEFAULT) cur_d = 8'h3C;
    while ((n_acc < 1000 || in_q.size() != 0) && cyc < 20000) begin
      wr   = (n_acc < 1000) && ($urandom_range(3) != 0);
      trdy = ($urandom_range(9) < 7);
      step(wr, cur_cmd, cur_d, trdy);
      cyc++;
      chk("rnd_no_err", 9'(s_err), 9'd0);
      if (s_wr) begin
        chk("rnd_wr_gated", 9'(trdy), 9'd1);
        if (!esc_pend && s_data == ESC_DEFAULT) begin
          esc_pend = 1'b1;
        end else begin
          if (esc_pend) dec = (s_data == ESC_DEFAULT) ? {1'b0, ESC_DEFAULT} : {1'b1, s_data};
          else          dec = {1'b0, s_data};
          esc_pend = 1'b0;
          chk("rnd_expected_any", 9'(in_q.size() != 0), 9'd1);
          if (in_q.size() != 0) chk("rnd_decoded", dec, in_q.pop_front());
        end
      end
      if (wr && s_rdy) begin
        chk("rnd_single_pending", 9'(in_q.size()), 9'd0);
        in_q.push_back({cur_cmd, cur_d});
        n_acc++;
        cur_cmd = ($urandom_range(3) == 0);
        cur_d   = ($urandom_range(3) == 0) ? ESC_DEFAULT : 8'($urandom);
        if (cur_cmd && cur_d == ESC_DEFAULT) cur_d = 8'h3C;
      end
    end
    chk("rnd_all_accepted", 9'(n_acc == 1000), 9'd1);
    chk("rnd_drained", 9'(in_q.size()), 9'd0);
    chk("rnd_no_dangling_esc", 9'(esc_pend), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
